// File: rtl/retro_memory_read_queue_pkg.sv
// Shared constants for the retro memory read queue and its memory port.
// The only port type is the IRetroMemoryPort interface; widths derived from parameters stay local.
package retro_memory_read_queue_pkg;
    localparam int unsigned BYTE_BITS = 8;
endpackage

// File: rtl/retro_memory_port_if.sv
// Retro memory port: the initiator drives requests; the target returns read data with DataReady.
// Clk is owned by the environment and is only ever observed by either side.
interface IRetroMemoryPort
    import retro_memory_read_queue_pkg::*;
#(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1
) (
    input logic Clk
);
    logic                                  Access;
    logic                                  Write;
    logic [AddressBusWidth-1:0]            Address;
    logic [BYTE_BITS*DataBusWidth-1:0]     DToTarget;
    logic [DataBusWidth-1:0]               Mask;
    logic                                  Ready;
    logic                                  DataReady;
    logic [BYTE_BITS*DataBusWidth-1:0]     DToInitiator;

    modport Initiator (
        input  Clk, Ready, DataReady, DToInitiator,
        output Access, Write, Address, DToTarget, Mask
    );

    modport Target (
        input  Clk, Access, Write, Address, DToTarget, Mask,
        output Ready, DataReady, DToInitiator
    );
endinterface

// File: rtl/retro_sync_fifo.sv
// Synchronous FIFO with registered storage; head is valid the cycle after a push.
// No internal guarding: the caller never pushes when full or pops when empty.
module retro_sync_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         head,
    output logic [$clog2(Depth):0]   count
);
    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntWidth'(push) - CntWidth'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/retro_memory_read_queue.sv
// Credit-limited read queue in front of a retro memory port; reads return in issue order via a FIFO.
// Response one cycle after DataReady; reads stall once in-flight plus buffered reaches Depth, writes only on Ready.
module retro_memory_read_queue
    import retro_memory_read_queue_pkg::*;
#(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1,
    parameter int Depth           = 4
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              ReqValid,
    output logic                              ReqReady,
    input  logic                              ReqWrite,
    input  logic [AddressBusWidth-1:0]        ReqAddress,
    input  logic [BYTE_BITS*DataBusWidth-1:0] ReqData,
    input  logic [DataBusWidth-1:0]           ReqMask,
    output logic                              RespValid,
    input  logic                              RespReady,
    output logic [BYTE_BITS*DataBusWidth-1:0] RespData,
    output logic                              Orphan,
    IRetroMemoryPort.Initiator                Memory
);
    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;

    logic [CntWidth-1:0] in_flight;
    logic [CntWidth-1:0] count;
    logic                credit;
    logic                read_xfer;
    logic                push;
    logic                pop;
    logic                orphan_q;

    // Registered counters only, so freed credit is visible one cycle later.
    assign credit = ({1'b0, in_flight} + {1'b0, count}) < (CntWidth + 1)'(Depth);

    assign Memory.Access    = !Reset && ReqValid && (ReqWrite || credit);
    assign Memory.Address   = ReqAddress;
    assign Memory.DToTarget = ReqData;
    assign Memory.Mask      = ReqMask;
    assign Memory.Write     = ReqWrite;

    assign ReqReady  = !Reset && Memory.Ready && (ReqWrite || credit);
    assign read_xfer = ReqValid && ReqReady && !ReqWrite;
    assign push      = !Reset && Memory.DataReady && (in_flight != '0);
    assign RespValid = !Reset && (count != '0);
    assign pop       = RespValid && RespReady;
    assign Orphan    = orphan_q && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_flight <= '0;
            orphan_q  <= 1'b0;
        end else begin
            in_flight <= in_flight + CntWidth'(read_xfer) - CntWidth'(push);
            if (Memory.DataReady && (in_flight == '0)) begin
                orphan_q <= 1'b1;
            end
        end
    end

    retro_sync_fifo #(
        .Depth (Depth),
        .Width (BYTE_BITS * DataBusWidth)
    ) u_fifo (
        .clk       (Clk),
        .reset     (Reset),
        .push      (push),
        .push_data (Memory.DToInitiator),
        .pop       (pop),
        .head      (RespData),
        .count     (count)
    );
endmodule
